// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one combinational alu between two requesters. A round-robin grant
//   picks a requester in IDLE, its operands are latched, the alu result is
//   registered in EXEC, and the response is held in RESP until the consumer
//   takes it. One operation is in flight at a time (minimum 3 cycles each).
//
// Ports (alu_arbiter):
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high; clears all state
//   req0_valid     in   requester 0 has an operation
//   req0_a/b       in   requester 0 operands [WIDTH-1:0]
//   req0_op        in   requester 0 ALUOp [OPW-1:0]
//   req0_ready     out  requester 0 accepted this cycle (combinational)
//   req1_*         -    same set for requester 1
//   rsp_valid      out  result available
//   rsp_data       out  registered alu result [WIDTH-1:0]
//   rsp_id         out  requester that owns rsp_data
//   rsp_ready      in   consumer takes the result (only looked at in RESP)
//   busy           out  state != IDLE
//   cnt0/cnt1      out  saturating per-requester completion counters
//                       [CNT_W-1:0], present only with ALU_ARB_CNT_EN
//
// Configuration macro:
//   ALU_ARB_CNT_EN  - when defined, adds the cnt0/cnt1 ports and counters.
//
// Ports (alu):
//   A, B   in   operands [WIDTH-1:0]
//   ALUOp  in   operation select [OPW-1:0]
//   C      out  result [WIDTH-1:0]
//
// ALUOp encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor,
//                 101 signed set-less-than, 110 shift left, 111 shift right.
// ---------------------------------------------------------------------------

module alu #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   ALUOp,
  output logic [WIDTH-1:0] C
);

  // Plain combinational decode; add/sub wrap around at WIDTH bits and no
  // flags are produced. Shift amounts use the low five bits of B.
  always_comb begin
    C = '0;
    case (ALUOp)
      3'b000:  C = A + B;
      3'b001:  C = A - B;
      3'b010:  C = A & B;
      3'b011:  C = A | B;
      3'b100:  C = A ^ B;
      3'b101:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      3'b110:  C = A << B[4:0];
      3'b111:  C = A >> B[4:0];
      default: C = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy
`ifdef ALU_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // The embedded alu is a fixed 32-bit, 3-bit-opcode unit, and the counters
  // need at least one bit; reject any other configuration at elaboration.
  if (WIDTH != 32) begin : g_bad_width
    $error("alu_arbiter: only WIDTH=32 is supported");
  end
  if (OPW != 3) begin : g_bad_opw
    $error("alu_arbiter: only OPW=3 is supported");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("alu_arbiter: CNT_W must be at least 1");
  end

  logic [1:0]       state;
  logic             last;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_c;
  logic             grant0;
  logic             grant1;

  // The alu only ever sees the latched operands, so requesters are free to
  // change their inputs as soon as they have been accepted.
  alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .A     (a_q),
    .B     (b_q),
    .ALUOp (op_q),
    .C     (alu_c)
  );

  // Grant selection. A lone valid requester always wins; when both are
  // valid, the one that did not win the last contended grant goes next.
  // last resets to 1 so requester 0 takes the first contended grant.
  // The two terms are mutually exclusive, so both readys never rise together.
  always_comb begin
    grant0 = (state == IDLE) && req0_valid && (!req1_valid || last);
    grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  // Main controller: IDLE latches the granted request, EXEC captures the
  // alu result into the response registers, RESP holds the response until
  // the consumer takes it. An asynchronous reset drops any in-flight work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q   <= grant1 ? req1_a  : req0_a;
            b_q   <= grant1 ? req1_b  : req0_b;
            op_q  <= grant1 ? req1_op : req0_op;
            id_q  <= grant1;
            if (req0_valid && req1_valid) begin
              last <= grant1;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_c;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_CNT_EN
  logic handoff;

  assign handoff = (state == RESP) && rsp_ready;

  // Per-requester completion counters. A response counts when it is handed
  // off to the consumer; each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (handoff) begin
      if (!rsp_id && (cnt0 != {CNT_W{1'b1}})) begin
        cnt0 <= cnt0 + 1'b1;
      end
      if (rsp_id && (cnt1 != {CNT_W{1'b1}})) begin
        cnt1 <= cnt1 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Purpose:
//   Self-checking bench for alu_arbiter. Each scenario task drives its own
//   stimulus, pushes the expected response onto a scoreboard queue when a
//   request is accepted, and pops/compares it when the DUT presents the
//   response. Inputs are driven and outputs sampled 1 ns after the rising
//   clock edge.
//
// Configuration macro:
//   ALU_ARB_CNT_EN - when defined, the counter ports are connected and the
//                    counter scenario is run.
// ---------------------------------------------------------------------------

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_op;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_op;
  logic        req1_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        rsp_ready;
  logic        busy;
`ifdef ALU_ARB_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  typedef struct {
    logic [31:0] data;
    logic        id;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
`ifdef ALU_ARB_CNT_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
`endif
    .busy       (busy)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case a scenario gets stuck despite its bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the oldest expected response and compares it with the DUT output.
  // Called only once rsp_valid has been seen high.
  task automatic pop_and_compare(input string name);
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_unexpected: rsp_data=%0d rsp_id=%0d with empty scoreboard", name, rsp_data, rsp_id);
    end else begin
      e = sb.pop_front();
      if (rsp_data !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL %s_data: got %0d expected %0d", name, rsp_data, e.data);
      end
      tests_run++;
      if (rsp_id !== e.id) begin
        tests_failed++;
        $display("[TB] FAIL %s_id: got %0d expected %0d", name, rsp_id, e.id);
      end
    end
  endtask

  // Waits (bounded) for rsp_valid, then checks the response against the
  // scoreboard. A timeout counts as a failure.
  task automatic wait_response(input string name);
    for (int k = 0; k < 10 && rsp_valid !== 1'b1; k++) tick();
    if (rsp_valid !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_timeout: rsp_valid got %0b expected 1", name, rsp_valid);
    end else begin
      pop_and_compare(name);
    end
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Reset state of all outputs, both while reset is held and after release.
  task automatic test_reset();
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    tests_run++;
    if (rsp_data !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rsp_data: got %0d expected 0", rsp_data); end
    tests_run++;
    if (rsp_id !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_id: got %0b expected 0", rsp_id); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    reset = 1'b0;
    tick();
    tests_run++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready_idle: got %0b%0b expected 00", req0_ready, req1_ready);
    end
  endtask

  // One add from requester 0: 5 + 3 = 8, one cycle of EXEC latency.
  task automatic test_single_op();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b000;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_ready: got %0b%0b expected 10", req0_ready, req1_ready);
    end
    sb.push_back('{32'd8, 1'b0});
    tick();
    req0_valid = 1'b0;
    req0_a     = 32'hdead_beef;
    tests_run++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_exec: busy/rsp_valid got %0b%0b expected 10", busy, rsp_valid);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_latency: rsp_valid got %0b expected 1", rsp_valid);
    end else begin
      pop_and_compare("single");
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_return_idle: busy/rsp_valid got %0b%0b expected 00", busy, rsp_valid);
    end
  endtask

  // Both requesters valid from reset: grants alternate 0,1,0,1,0.
  task automatic test_contention();
    logic exp_id;
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 32'd1;  req1_b = 32'd1; req1_op = 3'b000;
    #1;
    for (int n = 0; n < 5; n++) begin
      exp_id = n[0];
      for (int k = 0; k < 8 && !(req0_ready || req1_ready); k++) tick();
      tests_run++;
      if (req0_ready && req1_ready) begin
        tests_failed++;
        $display("[TB] FAIL contention_both_ready: got 11 expected one-hot");
      end
      tests_run++;
      if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
        tests_failed++;
        $display("[TB] FAIL contention_grant%0d: ready got %0b%0b expected %0b%0b", n, req0_ready, req1_ready, !exp_id, exp_id);
      end
      sb.push_back(exp_id ? '{32'd2, 1'b1} : '{32'd6, 1'b0});
      tick();
      wait_response("contention");
      if (n == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
    end
  endtask

  // Response held for 5 cycles with rsp_ready low while requester 0 waits.
  task automatic test_backpressure();
    rsp_ready  = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd23; req1_op = 3'b001;
    #1;
    tests_run++;
    if (req1_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_accept: req1_ready got %0b expected 1", req1_ready); end
    sb.push_back('{32'd77, 1'b1});
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b000;
    tick();
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_scoreboard: queue size got 0 expected 1");
    end else begin
      e = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id) begin
          tests_failed++;
          $display("[TB] FAIL bp_hold%0d: valid/data/id got %0b/%0d/%0b expected 1/%0d/%0b", k, rsp_valid, rsp_data, rsp_id, e.data, e.id);
        end
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL bp_ready%0d: got %0b%0b expected 00", k, req0_ready, req1_ready);
        end
        tick();
      end
    end
    rsp_ready = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: busy/rsp_valid/req0_ready got %0b%0b%0b expected 001", busy, rsp_valid, req0_ready);
    end
    // Requester 0 withdraws before being accepted: no grant may be taken.
    req0_valid = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_withdraw: busy got %0b expected 0", busy); end
  endtask

  // Requester 1 scrambles its inputs right after acceptance: 7 + 2 = 9.
  task automatic test_input_change();
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd2; req1_op = 3'b000;
    #1;
    tests_run++;
    if (req1_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL inchg_accept: req1_ready got %0b expected 1", req1_ready); end
    sb.push_back('{32'd9, 1'b1});
    tick();
    req1_valid = 1'b0;
    req1_a = 32'd1000; req1_b = 32'd5000; req1_op = 3'b001;
    wait_response("inchg");
    tick();
  endtask

  // Reset during EXEC clears outputs at once and restores requester-0 priority.
  task automatic test_reset_mid_op();
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd5; req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 32'd3;  req1_b = 32'd4; req1_op = 3'b000;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_first: req0_ready got %0b expected 1", req0_ready); end
    tick();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_exec: busy got %0b expected 1", busy); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_async: rsp_valid/busy got %0b%0b expected 00", rsp_valid, busy);
    end
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_regrant: ready got %0b%0b expected 10", req0_ready, req1_ready);
    end
    sb.push_back('{32'd15, 1'b0});
    tick();
    wait_response("rstmid");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

`ifdef ALU_ARB_CNT_EN
  // Three completions for requester 0 and two for requester 1.
  task automatic test_counters();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        req0_valid = 1'b1; req0_a = i; req0_b = 32'd1; req0_op = 3'b000;
        sb.push_back('{i + 1, 1'b0});
      end else begin
        req1_valid = 1'b1; req1_a = i; req1_b = 32'd1; req1_op = 3'b000;
        sb.push_back('{i + 1, 1'b1});
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_response("cnt_op");
      tick();
    end
    tests_run++;
    if (cnt0 !== 16'd3) begin tests_failed++; $display("[TB] FAIL cnt0: got %0d expected 3", cnt0); end
    tests_run++;
    if (cnt1 !== 16'd2) begin tests_failed++; $display("[TB] FAIL cnt1: got %0d expected 2", cnt1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_input_change();
    test_reset_mid_op();
`ifdef ALU_ARB_CNT_EN
    test_counters();
`endif
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
